// File: rtl/stream_demux1x4_pkg.sv
`default_nettype none
// ============================================================================
// Package  : demux_pkg
// Brief    : Shared constants, types and helpers for the 1-to-4 stream demux.
// Revision : 1.0  initial release
// ============================================================================
package demux_pkg;

    localparam int NCH       = 4;
    localparam int SEL_W     = 2;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W     = 16;

    typedef logic [SEL_W-1:0] chan_sel_t;

    // Round-robin successor; the 2-bit width gives the 3->0 wrap for free.
    function automatic chan_sel_t next_chan(input chan_sel_t cur);
        return cur + chan_sel_t'(1);
    endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/stream_demux1x4_if.sv
`default_nettype none
// ============================================================================
// Interface : stream_demux1x4_if
// Brief     : Upstream input handshake plus the four downstream channels.
// Revision  : 1.0  initial release
// ============================================================================
interface stream_demux1x4_if
    import demux_pkg::*;
#(
    parameter int DW = DW_DEF
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic [SEL_W-1:0]     in_sel;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic [NCH*DW-1:0]    out_data;

    // Environment side: drives the input word and the downstream readies.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface : stream_demux1x4_if
`default_nettype wire

// File: rtl/stream_demux1x4_chan_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux_chan_buf
// Brief    : DEPTH-entry FIFO for one output channel; head reads 0 when empty.
// Revision : 1.0  initial release
// ============================================================================
module demux_chan_buf
    import demux_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          push,
    input  wire logic [DW-1:0] wdata,
    input  wire logic          pop,
    output logic               full,
    output logic               empty,
    output logic [DW-1:0]      head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads from registered state only, so a fresh word shows next cycle.
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : demux_chan_buf
`default_nettype wire

// File: rtl/stream_demux1x4.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux1x4
// Brief    : 1-to-4 stream demultiplexer, select- or round-robin-directed.
// Revision : 1.0  initial release
// ============================================================================
module stream_demux1x4
    import demux_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          rr_mode,
    stream_demux1x4_if.slave   s,
    output logic               busy,
    output logic [CNT_W-1:0]   acc_cnt
);

    chan_sel_t          rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    chan_sel_t          target;
    logic               in_ready_int;
    logic               accept;
    logic [NCH-1:0]     push;
    logic [NCH-1:0]     pop;
    logic [NCH-1:0]     full;
    logic [NCH-1:0]     empty;
    logic [DW-1:0]      head [NCH];
    logic [NCH*DW-1:0]  out_data_int;

    // Readiness depends only on stored occupancy, never on out_ready.
    always_comb begin
        target       = rr_mode ? rr_ptr_q : s.in_sel;
        in_ready_int = rst_n && !full[target];
        accept       = s.in_valid && in_ready_int;
        for (int k = 0; k < NCH; k++) begin
            push[k] = accept && (target == chan_sel_t'(k));
            pop[k]  = !empty[k] && s.out_ready[k];
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        acc_cnt_d = acc_cnt_q;
        if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
            if (rr_mode) begin
                rr_ptr_d = next_chan(rr_ptr_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            acc_cnt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan_buf #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .wdata (s.in_data),
            .pop   (pop[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .head  (head[k])
        );
    end

    always_comb begin
        out_data_int = '0;
        for (int k = 0; k < NCH; k++) begin
            out_data_int[k*DW +: DW] = head[k];
        end
    end

    assign s.in_ready  = in_ready_int;
    assign s.out_valid = ~empty;
    assign s.out_data  = out_data_int;
    assign busy        = |(~empty);
    assign acc_cnt     = acc_cnt_q;

endmodule : stream_demux1x4
`default_nettype wire
